dot8s_accum: RTL and testbench
==============================

// Module: dot8s_accum
// PURPOSE
//   Streaming signed dot-product engine. Sits directly downstream of the 8x8 signed array
//   multiplier and consumes its 16-bit two's-complement product. Operand pairs arrive
//   with valid/ready flow control; the block accumulates products until in_last, then
//   presents one sum per vector. Used to measure multiplier error at kernel level.
// PARAMETERS
//   ACC_W  24  accumulator/result width; products sign-extended 16->ACC_W
//   LEN_W  8   element counter width; max vector length 2**LEN_W-1
// PORTS
//   clk        in   1      single clock, rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      operand pair valid
//   in_ready   out  1      block accepts pair this cycle
//   in_a       in   8      signed operand A
//   in_b       in   8      signed operand B
//   in_last    in   1      pair is final element of vector
//   out_valid  out  1      result valid; held until out_ready
//   out_ready  in   1      consumer accepts result
//   out_sum    out  ACC_W  signed dot product, wrap-around arithmetic
//   out_count  out  LEN_W  number of elements in vector
//   out_ovf    out  1      sticky: signed overflow of out_sum occurred in vector
//   out_trunc  out  1      vector force-closed at max length (no in_last seen)
// BEHAVIOUR
//   - Reset: in_ready=0 during rst, 1 the cycle after; out_valid=0, out_sum=0,
//     out_count=0, out_ovf=0, out_trunc=0; all pipeline valids, accumulator, counter = 0.
//   - Global advance en = !out_valid | out_ready; in_ready = en & !rst.
//     All pipe regs hold when en=0. Accept = in_valid & in_ready.
//   - Stage P (cycle t+1): register a, b, last, valid.
//   - Stage M (t+2): register 16-bit signed product of P operands from multiplier
//     sub-module, plus last/valid.
//   - Stage A (t+3): if M.valid: acc_nx = base + sext(prod), base = acc (or 0 on
//     first element after a close); cnt_nx = cnt+1 (or 1). Overflow = operand signs
//     equal and result sign differs; ORed into sticky flag (cleared on vector start).
//   - Close: M.last, or cnt_nx == 2**LEN_W-1 (then out_trunc=1). On close, out_* load
//     acc_nx/cnt_nx/flags, out_valid=1, accumulator marked empty for next vector.
//     Latency in_last accept -> out_valid = 3 cycles.
//   - out_valid & out_ready & new close same cycle: new result overwrites, out_valid stays 1.
//   - out_valid & !out_ready: whole pipe stalls; out_* stable; no element lost/duplicated.
//   - Bubbles (in_valid=0) pass through P/M without touching accumulator.
//   - Back-to-back vectors: element after in_last starts from 0 with no idle cycle.
//   - rst mid-vector: partial sum, flags and in-flight pairs discarded; out_valid=0.
//   - State machine (accumulator): EMPTY -> ACCUM on non-closing M.valid; ACCUM -> EMPTY
//     on close; EMPTY -> EMPTY on single-element close.
// STRUCTURE
//   - Package dot8s_pkg: PROD_W=16, OPND_W=8, typedef prod_t (signed [15:0]),
//     opnd_t (signed [7:0]), function sext_prod(prod_t) -> ACC_W.
//   - One sub-module: the library 8x8 signed multiplier (exact variant), instantiated
//     combinationally between stages P and M; swappable for approximate variants,
//     same A/B/O port list.
//   - Top holds P/M registers, accumulator FSM, counter, output register.
// TESTING
//   1. Vector (3,4),(-2,5),(7,-1)+last -> out_sum=-5, count=3, ovf=0, out_valid 3 cycles
//      after last accept.
//   2. (-128,-128) x 2 + last, ACC_W=16 -> out_sum=-32768 (wrapped), ovf=1; next vector
//      (1,1)+last -> sum=1, ovf=0.
//   3. 255 elements (1,1), no last, LEN_W=8 -> sum=255, count=255, trunc=1; element 256
//      starts new vector.
//   4. out_ready=0 for 10 cycles with 2 vectors queued -> in_ready=0, first result stable,
//      second emitted after handshake; both sums correct.
//   5. Single-element vectors back-to-back, out_ready=1 -> one result per cycle, no gaps.
//   6. rst asserted after 2 of 4 elements -> out_valid=0; new vector (2,3)+last -> sum=6,
//      count=1.

Source files
------------

// File: rtl/dot8s_pkg.sv
// Shared types and helpers for the signed 8x8 dot-product engine.
package dot8s_pkg;

  localparam int OPND_W    = 8;
  localparam int PROD_W    = 16;
  localparam int ACC_MAX_W = 64;

  typedef logic signed [OPND_W-1:0] opnd_t;
  typedef logic signed [PROD_W-1:0] prod_t;

  typedef enum logic {
    ACC_EMPTY = 1'b0,
    ACC_ACCUM = 1'b1
  } acc_state_t;

  // Callers narrow the result to their own accumulator width with a size cast.
  function automatic logic signed [ACC_MAX_W-1:0] sext_prod(input prod_t p);
    return {{(ACC_MAX_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

endpackage

// File: rtl/dot8s_accum_mul.sv
// Exact 8x8 signed multiplier; approximate variants share this A/B/O port list.
module mul8s_exact
  import dot8s_pkg::*;
(
  input  opnd_t A,
  input  opnd_t B,
  output prod_t O
);

  assign O = prod_t'(A) * prod_t'(B);

endmodule

// File: rtl/dot8s_accum.sv
// Streaming signed dot-product: P (operands) -> M (product) -> A (accumulate/close).
module dot8s_accum
  import dot8s_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [OPND_W-1:0] in_a,
  input  logic signed [OPND_W-1:0] in_b,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_sum,
  output logic [LEN_W-1:0]         out_count,
  output logic                     out_ovf,
  output logic                     out_trunc
);

  localparam logic [LEN_W-1:0] CNT_MAX = '1;

  logic             r_p_valid, r_p_last;
  opnd_t            r_p_a, r_p_b;
  logic             r_m_valid, r_m_last;
  prod_t            r_m_prod;
  acc_state_t       r_state, w_state_nx;
  logic [ACC_W-1:0] r_acc;
  logic [LEN_W-1:0] r_cnt;
  logic             r_ovf;
  logic             r_out_valid, r_out_ovf, r_out_trunc;
  logic [ACC_W-1:0] r_out_sum;
  logic [LEN_W-1:0] r_out_cnt;

  logic             w_en;
  prod_t            w_prod;
  logic [ACC_W-1:0] w_prod_ext, w_acc_base, w_acc_nx;
  logic [LEN_W-1:0] w_cnt_base, w_cnt_nx;
  logic             w_ovf_base, w_ovf_nx, w_cnt_full, w_close;

  // A pending result that the consumer refuses freezes every stage at once.
  assign w_en     = !r_out_valid | out_ready;
  assign in_ready = w_en & !rst;

  mul8s_exact u_mul (
    .A (r_p_a),
    .B (r_p_b),
    .O (w_prod)
  );

  // NOTE: clocked state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p_valid <= 1'b0;
      r_p_last  <= 1'b0;
      r_p_a     <= '0;
      r_p_b     <= '0;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
      r_m_prod  <= '0;
    end else if (w_en) begin
      r_p_valid <= in_valid;
      r_p_last  <= in_last;
      r_p_a     <= in_a;
      r_p_b     <= in_b;
      r_m_valid <= r_p_valid;
      r_m_last  <= r_p_last;
      r_m_prod  <= w_prod;
    end
  end

  assign w_prod_ext = ACC_W'(sext_prod(r_m_prod));

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_state_nx = r_state;
    w_acc_base = r_acc;
    w_cnt_base = r_cnt;
    w_ovf_base = r_ovf;
    if (r_state == ACC_EMPTY) begin
      w_acc_base = '0;
      w_cnt_base = '0;
      w_ovf_base = 1'b0;
    end
    w_acc_nx   = w_acc_base + w_prod_ext;
    w_cnt_nx   = w_cnt_base + LEN_W'(1);
    // Signed overflow: addends agree in sign but the sum does not.
    w_ovf_nx   = w_ovf_base |
                 ((w_acc_base[ACC_W-1] == w_prod_ext[ACC_W-1]) &&
                  (w_acc_nx[ACC_W-1] != w_acc_base[ACC_W-1]));
    w_cnt_full = (w_cnt_nx == CNT_MAX);
    w_close    = r_m_valid & (r_m_last | w_cnt_full);
    if (r_m_valid) begin
      w_state_nx = w_close ? ACC_EMPTY : ACC_ACCUM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ACC_EMPTY;
    end else if (w_en) begin
      r_state <= w_state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_cnt   <= '0;
      r_out_ovf   <= 1'b0;
      r_out_trunc <= 1'b0;
    end else if (w_en) begin
      if (r_m_valid) begin
        r_acc <= w_acc_nx;
        r_cnt <= w_cnt_nx;
        r_ovf <= w_ovf_nx;
      end
      // A fresh close overwrites a result being handed off in the same cycle.
      r_out_valid <= w_close;
      if (w_close) begin
        r_out_sum   <= w_acc_nx;
        r_out_cnt   <= w_cnt_nx;
        r_out_ovf   <= w_ovf_nx;
        r_out_trunc <= w_cnt_full & !r_m_last;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_count = r_out_cnt;
  assign out_ovf   = r_out_ovf;
  assign out_trunc = r_out_trunc;

endmodule

// File: tb/tb_dot8s_accum.sv
// Scoreboard bench for dot8s_accum: directed vectors, monitor pops on each output handshake.
module tb_dot8s_accum;

  localparam int ACC_W = 16;
  localparam int LEN_W = 8;

  typedef struct packed {
    logic [ACC_W-1:0] sum;
    logic [LEN_W-1:0] cnt;
    logic             ovf;
    logic             trunc;
  } res_t;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid, in_ready, in_last;
  logic signed [7:0]       in_a, in_b;
  logic                    out_valid, out_ready;
  logic signed [ACC_W-1:0] out_sum;
  logic [LEN_W-1:0]        out_count;
  logic                    out_ovf, out_trunc;

  res_t exp_q[$];
  int   hs_cyc[$];
  int   cyc = 0;
  int   last_accept_cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  res_t mon_exp, mon_got;

  dot8s_accum #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf),
    .out_trunc (out_trunc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  function automatic res_t mk(input int s, input int c, input bit o, input bit t);
    res_t r;
    r.sum   = ACC_W'(s);
    r.cnt   = LEN_W'(c);
    r.ovf   = o;
    r.trunc = t;
    return r;
  endfunction

  // Monitor: one expected result consumed per output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      hs_cyc.push_back(cyc);
      mon_got = {out_sum, out_count, out_ovf, out_trunc};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL result: got unexpected sum=%0d cnt=%0d, expected none",
                 $signed(mon_got.sum), mon_got.cnt);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          n_errors++;
          $display("FAIL result: got sum=%0d cnt=%0d ovf=%0b trunc=%0b, expected sum=%0d cnt=%0d ovf=%0b trunc=%0b",
                   $signed(mon_got.sum), mon_got.cnt, mon_got.ovf, mon_got.trunc,
                   $signed(mon_exp.sum), mon_exp.cnt, mon_exp.ovf, mon_exp.trunc);
        end
      end
    end
  end

  task automatic send(input int a, input int b, input bit last);
    int guard = 0;
    in_a     = 8'(a);
    in_b     = 8'(b);
    in_last  = last;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    if (!in_ready) begin
      fail_now("send_timeout");
    end else begin
      last_accept_cyc = cyc;
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      guard++;
      @(posedge clk);
    end
    if (exp_q.size() != 0) begin
      fail_now("drain_timeout");
      exp_q.delete();
    end
    #1;
  endtask

  task automatic wait_hs(input int n);
    int guard = 0;
    while (hs_cyc.size() < n && guard < 100) begin
      guard++;
      @(posedge clk);
    end
    if (hs_cyc.size() < n) fail_now("handshake_timeout");
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  in_ready,  0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum",   out_sum,   0);
    check("rst_out_count", out_count, 0);
    check("rst_out_ovf",   out_ovf,   0);
    check("rst_out_trunc", out_trunc, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // 1: basic vector and in_last -> out_valid latency
    hs_cyc.delete();
    exp_q.push_back(mk(-5, 3, 0, 0));
    send(3, 4, 0);
    send(-2, 5, 0);
    send(7, -1, 1);
    wait_hs(1);
    if (hs_cyc.size() > 0) check("latency", hs_cyc[0] - last_accept_cyc, 3);
    drain();

    // 2: wrap-around with sticky overflow, then a clean vector
    exp_q.push_back(mk(-32768, 2, 1, 0));
    send(-128, -128, 0);
    send(-128, -128, 1);
    exp_q.push_back(mk(1, 1, 0, 0));
    send(1, 1, 1);
    drain();

    // 3: force-close at maximum length, next element opens a new vector
    exp_q.push_back(mk(255, 255, 0, 1));
    for (int i = 0; i < 255; i++) send(1, 1, 0);
    exp_q.push_back(mk(1, 1, 0, 0));
    send(1, 1, 1);
    drain();

    // 4: consumer stall with a second vector in flight
    out_ready = 1'b0;
    exp_q.push_back(mk(26, 2, 0, 0));
    send(2, 3, 0);
    send(4, 5, 1);
    exp_q.push_back(mk(-7, 1, 0, 0));
    send(1, -7, 1);
    begin
      int guard = 0;
      @(negedge clk);
      while (!out_valid && guard < 20) begin
        guard++;
        @(negedge clk);
      end
      if (!out_valid) fail_now("stall_wait");
    end
    for (int i = 0; i < 10; i++) begin
      check("stall_in_ready", in_ready, 0);
      check("stall_out_sum",  out_sum,  26);
      @(negedge clk);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    // 5: single-element vectors back-to-back, one result per cycle
    hs_cyc.delete();
    for (int i = 1; i <= 5; i++) begin
      exp_q.push_back(mk(-3 * i, 1, 0, 0));
      send(i, -3, 1);
    end
    wait_hs(5);
    for (int i = 1; i < 5; i++) begin
      if (hs_cyc.size() > i) check("b2b_gap", hs_cyc[i] - hs_cyc[i-1], 1);
    end
    drain();

    // 6: reset mid-vector discards the partial sum
    send(1, 1, 0);
    send(1, 1, 0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready",  in_ready,  0);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.push_back(mk(6, 1, 0, 0));
    send(2, 3, 1);
    drain();
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("idle_out_valid", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
